cla_pipe: RTL and testbench

CLA_PIPE -- requirements
Module: cla_pipe

---
 rtl/cla_pipe.sv | 120 ++++++++++++
 tb/tb_cla_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cla_pipe : two-stage ready/valid carry-lookahead adder back end.          |
// |            Takes per-bit p/g/h and carry-in; emits sum, cout, ovf, gp, gg.|
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module cla_pipe #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] p,
  input  logic [W-1:0] g,
  input  logic [W-1:0] h,
  input  logic         c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         gp,
  output logic         gg
);

  logic         r_s1_valid;
  logic [W-1:0] r_s1_p;
  logic [W-1:0] r_s1_g;
  logic [W-1:0] r_s1_h;
  logic         r_s1_c;

  logic         r_s2_valid;
  logic [W-1:0] r_s;
  logic         r_cout;
  logic         r_ovf;
  logic         r_gp;
  logic         r_gg;

  logic         w_s1_adv;
  logic         w_s2_adv;
  logic [W:0]   w_carry;
  logic         w_gg;

  // Carry into bit idx as a flat sum of products: every generate term is
  // ANDed with the propagates above it, so no term depends on another carry.
  function automatic logic carry_at(input logic [W-1:0] fp, input logic [W-1:0] fg,
                                    input logic fc0, input int idx);
    logic acc;
    logic term;
    acc = fc0;
    for (int k = 0; k < idx; k++) acc = acc & fp[k];
    for (int j = 0; j < idx; j++) begin
      term = fg[j];
      for (int k = j + 1; k < idx; k++) term = term & fp[k];
      acc = acc | term;
    end
    return acc;
  endfunction

  genvar i;
  generate
    for (i = 0; i <= W; i++) begin : g_carry
      assign w_carry[i] = carry_at(r_s1_p, r_s1_g, r_s1_c, i);
    end
  endgenerate

  assign w_gg     = carry_at(r_s1_p, r_s1_g, 1'b0, W);
  assign w_s2_adv = ~r_s2_valid | out_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;
  assign in_ready = w_s1_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_p     <= '0;
      r_s1_g     <= '0;
      r_s1_h     <= '0;
      r_s1_c     <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_p <= p;
        r_s1_g <= g;
        r_s1_h <= h;
        r_s1_c <= c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s        <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_gp       <= 1'b0;
      r_gg       <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      // Result registers only change on a real load, so they hold while stalled.
      if (r_s1_valid) begin
        r_s    <= r_s1_h ^ w_carry[W-1:0];
        r_cout <= w_carry[W];
        r_ovf  <= w_carry[W] ^ w_carry[W-1];
        r_gp   <= &r_s1_p;
        r_gg   <= w_gg;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign gp        = r_gp;
  assign gg        = r_gg;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cla_pipe : self-checking bench for cla_pipe against an arithmetic     |
// |               model of a+b+cin with a FIFO scoreboard.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cla_pipe;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W-1:0] h;
  logic         c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         gp;
  logic         gg;

  logic [W-1:0] a_drv;
  logic [W-1:0] b_drv;

  typedef struct {
    logic [W+3:0] res;
    int           t;
  } exp_t;

  exp_t         q[$];
  int           n_asserts;
  int           n_fail;
  int           cyc;
  bit           lat_on;
  bit           prev_hold;
  logic [W+3:0] prev_out;

  assign p = a_drv | b_drv;
  assign g = a_drv & b_drv;
  assign h = a_drv ^ b_drv;

  cla_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p),
    .g         (g),
    .h         (h),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .gp        (gp),
    .gg        (gg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: {s, cout, ovf, gp, gg} for a + b + cin.
  function automatic logic [W+3:0] ref_model(input int a, input int b, input int ci);
    int           full;
    int           sa;
    int           sb;
    int           ssum;
    logic [W+3:0] r;
    full = a + b + ci;
    sa   = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb   = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    ssum = sa + sb + ci;
    r[W+3:4] = W'(full % (1 << W));
    r[3]     = (full >= (1 << W));
    r[2]     = (ssum > (1 << (W - 1)) - 1) || (ssum < -(1 << (W - 1)));
    r[1]     = ((a | b) == (1 << W) - 1);
    r[0]     = ((a + b) >= (1 << W));
    return r;
  endfunction

  // One clock cycle: apply inputs, check handshake and any result, then step.
  task automatic drive(input logic v, input int a, input int b, input logic ci,
                       input logic ordy, input bit use_lit = 1'b0,
                       input logic [W+3:0] lit = '0);
    logic [W+3:0] obs;
    exp_t         e;
    in_valid  = v;
    a_drv     = a[W-1:0];
    b_drv     = b[W-1:0];
    c         = ci;
    out_ready = ordy;
    #1;
    obs = {s, cout, ovf, gp, gg};
    if (prev_hold) check("hold_stable", 32'(obs), 32'(prev_out));
    check("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !ordy)));
    if (out_valid && out_ready) begin
      check("spurious_result", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("result", 32'(obs), 32'(e.res));
        if (lat_on) check("latency", 32'(cyc - e.t), 32'd2);
      end
    end
    if (in_valid && in_ready) begin
      e.res = use_lit ? lit : ref_model(a % (1 << W), b % (1 << W), int'(ci));
      e.t   = cyc;
      q.push_back(e);
    end
    prev_hold = out_valid && !out_ready;
    prev_out  = obs;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    cyc       = 0;
    lat_on    = 1'b1;
    prev_hold = 1'b0;
    prev_out  = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_drv     = '0;
    b_drv     = '0;
    c         = 1'b0;

    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_outputs", 32'({s, cout, ovf, gp, gg}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 5+3, 15+1 and 0+0+1 with literal expectations.
    drive(1'b1, 5, 3, 1'b0, 1'b1, 1'b1, 8'b1000_0_1_0_0);
    drive(1'b1, 15, 1, 1'b0, 1'b1, 1'b1, 8'b0000_1_0_1_1);
    drive(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 8'b0001_0_0_0_0);
    repeat (3) drive(1'b0, 0, 0, 1'b0, 1'b1);

    // Back-pressure: three offered sets, only two fit while stalled.
    lat_on = 1'b0;
    drive(1'b1, 2, 9, 1'b0, 1'b0);
    drive(1'b1, 7, 7, 1'b1, 1'b0);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    drive(1'b1, 12, 6, 1'b0, 1'b0);
    drive(1'b1, 12, 6, 1'b0, 1'b0);
    check("bp_gap0", 32'(out_valid), 32'd1);
    drive(1'b1, 12, 6, 1'b0, 1'b1);
    check("bp_gap1", 32'(out_valid), 32'd1);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    check("bp_gap2", 32'(out_valid), 32'd1);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b1);

    // Streaming: ten back-to-back random sets, result every cycle.
    lat_on = 1'b1;
    for (int i = 0; i < 10; i++)
      drive(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'b1);
    repeat (3) drive(1'b0, 0, 0, 1'b0, 1'b1);

    // Random valid/ready mix.
    lat_on = 1'b0;
    for (int i = 0; i < 60; i++)
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    repeat (4) drive(1'b0, 0, 0, 1'b0, 1'b1);

    // Reset mid-flight with two results in the pipe.
    lat_on = 1'b1;
    drive(1'b1, 3, 4, 1'b0, 1'b1);
    drive(1'b1, 9, 9, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_outputs", 32'({s, cout, ovf, gp, gg}), 32'd0);
    q.delete();
    prev_hold = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    drive(1'b1, 10, 11, 1'b1, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    repeat (2) drive(1'b0, 0, 0, 1'b0, 1'b1);

    check("drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
